// File: rtl/mem_instruction.sv
// mem_instruction: byte-addressed read-only instruction memory, boot image loaded on synchronous reset.
module mem_instruction #(
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] BASE_ADDR = 32'h64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int BASE = int'(BASE_ADDR);
    localparam logic [127:0] BOOT = {32'h00302023, 32'h002081B3, 32'h00300113, 32'h00500093};
    logic [7:0]  r_mem_instr [MEM_BYTES];
    logic [32:0] w_addr;
    logic [31:0] w_instr;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_BYTES; i++) r_mem_instr[i] <= 8'h00;
            for (int k = 0; k < 16; k++) r_mem_instr[BASE + k] <= BOOT[8*k +: 8];
        end
    end
    // 33-bit sum so a carry out of bit 31 lands out of range instead of wrapping
    always_comb begin
        w_instr = '0;
        w_addr = '0;
        for (int k = 0; k < 4; k++) begin
            w_addr = {1'b0, i_pc} + 33'(k);
            w_instr[8*k +: 8] = (w_addr < 33'(MEM_BYTES)) ? r_mem_instr[w_addr[AW-1:0]] : 8'h00;
        end
    end
    assign o_instr = w_instr;
endmodule

// File: tb/tb_mem_instruction.sv
// tb_mem_instruction: table-driven checks of reset load, combinational reads and out-of-range handling.
module tb_mem_instruction;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_pc = 32'h0;
    logic [31:0] o_instr;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];
    logic [31:0] img [4] = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00302023};

    mem_instruction dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_pc(i_pc),
        .o_instr(o_instr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [32:0] a);
        if (a >= 33'h64 && a < 33'h74) return img[(a - 33'h64) >> 2][8*((a - 33'h64) & 3) +: 8];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = model_byte({1'b0, pc} + 33'(k));
        return w;
    endfunction

    initial begin
        vecs.push_back('{32'h64, 32'h00500093});
        vecs.push_back('{32'h65, 32'h13005000});
        vecs.push_back('{32'h66, 32'h01130050});
        vecs.push_back('{32'h68, 32'h00300113});
        vecs.push_back('{32'h6C, 32'h002081B3});
        vecs.push_back('{32'h70, 32'h00302023});
        vecs.push_back('{32'h71, 32'h00003020});
        vecs.push_back('{32'h73, 32'h00000000});
        vecs.push_back('{32'h74, 32'h00000000});
        vecs.push_back('{32'h00, 32'h00000000});
        vecs.push_back('{32'hFC, 32'h00000000});
        vecs.push_back('{32'hFE, 32'h00000000});
        vecs.push_back('{32'h100, 32'h00000000});
        vecs.push_back('{32'hFFFFFFFE, 32'h00000000});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000});

        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_pc = 32'h64;
        #1;
        chk("reset_word_64", o_instr, 32'h00500093);
        chk("mem_64", 32'(dut.r_mem_instr[8'h64]), 32'h93);
        chk("mem_65", 32'(dut.r_mem_instr[8'h65]), 32'h00);
        chk("mem_66", 32'(dut.r_mem_instr[8'h66]), 32'h50);
        chk("mem_67", 32'(dut.r_mem_instr[8'h67]), 32'h00);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mem_68", 32'(dut.r_mem_instr[8'h68]), 32'h13);
        chk("mem_6C", 32'(dut.r_mem_instr[8'h6C]), 32'hB3);
        chk("mem_70", 32'(dut.r_mem_instr[8'h70]), 32'h23);
        chk("mem_FF", 32'(dut.r_mem_instr[8'hFF]), 32'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            i_pc = vecs[i].pc;
            #1;
            chk($sformatf("vec_pc_%h", vecs[i].pc), o_instr, vecs[i].exp);
            chk($sformatf("noX_pc_%h", vecs[i].pc), 32'($isunknown(o_instr)), 32'd0);
        end

        for (int a = 32'h64; a < 32'h74; a++) begin
            i_pc = 32'(a);
            #10;
            chk($sformatf("sweep_%h", a), o_instr, model_word(32'(a)));
            chk($sformatf("byte_%h", a), 32'(dut.r_mem_instr[a]), 32'(model_byte(33'(a))));
        end

        i_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge i_clk);
            #1;
            i_pc = vecs[i].pc;
            #1;
            chk($sformatf("hold_rst_pc_%h", vecs[i].pc), o_instr, vecs[i].exp);
        end
        i_rst = 1'b0;

        @(posedge i_clk);
        #2;
        i_pc = 32'h68;
        #1;
        chk("midcycle_68", o_instr, 32'h00300113);
        i_pc = 32'h70;
        #0;
        #0;
        chk("same_delta_70", o_instr, 32'h00302023);
        i_pc = 32'h6C;
        #1;
        chk("midcycle_6C", o_instr, 32'h002081B3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
